// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the immediate sequencer.
//   DATA_W   : width of a finished immediate
//   NIB_W    : width of one prefix nibble
//   MAX_NIBS : longest prefix chain that fits in DATA_W
//   COUNT_W  : width of the nibble counter (holds 0..MAX_NIBS)
//   state_t  : sequencer FSM states
package cpu_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NIB_W    = 4;
    localparam int unsigned MAX_NIBS = DATA_W / NIB_W;
    localparam int unsigned COUNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

endpackage

// File: rtl/imm_sequencer_if.sv
// Nibble-in / immediate-out handshake bundle for imm_sequencer.
//   in_valid/in_ready/in_nibble/in_last : decode -> sequencer nibble stream
//   out_valid/out_ready                 : sequencer -> operand-B mux handshake
//   out_imm/out_count/overflow_err      : finished immediate and its metadata
// Modports: master = decode/consumer side, slave = sequencer side.
interface imm_sequencer_if;

    logic                        in_valid;
    logic                        in_ready;
    logic [cpu_pkg::NIB_W-1:0]   in_nibble;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [cpu_pkg::DATA_W-1:0]  out_imm;
    logic [cpu_pkg::COUNT_W-1:0] out_count;
    logic                        overflow_err;

    modport master (
        output in_valid,
        output in_nibble,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_imm,
        input  out_count,
        input  overflow_err
    );

    modport slave (
        input  in_valid,
        input  in_nibble,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_imm,
        output out_count,
        output overflow_err
    );

endinterface

// File: rtl/signExtender.sv
// Sign-extends one NIB_W-bit nibble to DATA_W bits (purely combinational).
//   din  : input nibble, two's complement
//   dout : sign-extended result
module signExtender
    import cpu_pkg::*;
(
    input  logic [NIB_W-1:0]  din,
    output logic [DATA_W-1:0] dout
);

    assign dout = {{(DATA_W - NIB_W){din[NIB_W-1]}}, din};

endmodule

// File: rtl/imm_sequencer.sv
// Builds a signed DATA_W immediate from a chain of 1..MAX_NIBS nibbles. The first nibble
// is sign-extended; each later nibble is shifted in at the LSB end. The finished value is
// held until the consumer takes it.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : imm_sequencer_if.slave (nibble input stream and immediate output handshake)
module imm_sequencer
    import cpu_pkg::*;
(
    input logic            clk,
    input logic            rst,
    imm_sequencer_if.slave bus
);

    localparam logic [COUNT_W-1:0] LastCount = COUNT_W'(MAX_NIBS - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   sext_nib;
    logic                accept;

    signExtender u_sext (
        .din  (bus.in_nibble),
        .dout (sext_nib)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // No bypass: HOLD refuses nibbles until the result has been consumed.
    assign accept = bus.in_valid && (state_q != HOLD);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = sext_nib;
                    count_d = COUNT_W'(1);
                    err_d   = 1'b0;
                    state_d = bus.in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    // Dropped top bits are only sign copies while count stays <= MAX_NIBS.
                    acc_d   = {acc_q[DATA_W-NIB_W-1:0], bus.in_nibble};
                    count_d = count_q + COUNT_W'(1);
                    if (bus.in_last) begin
                        state_d = HOLD;
                    end else if (count_q == LastCount) begin
                        // Chain filled the word without in_last: force termination.
                        state_d = HOLD;
                        err_d   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result fields read as zero whenever no result is being offered.
    always_comb begin
        bus.in_ready     = (state_q != HOLD);
        bus.out_valid    = (state_q == HOLD);
        bus.out_imm      = '0;
        bus.out_count    = '0;
        bus.overflow_err = 1'b0;
        if (state_q == HOLD) begin
            bus.out_imm      = acc_q;
            bus.out_count    = count_q;
            bus.overflow_err = err_q;
        end
    end

endmodule

// File: tb/tb_imm_sequencer.sv
// Directed self-checking bench for imm_sequencer. Inputs are driven and outputs sampled
// 1 time unit after each rising edge.
module tb_imm_sequencer;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    imm_sequencer_if bus ();

    imm_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".out_imm"}, 32'(bus.out_imm), 32'd0);
        check({tag, ".out_count"}, 32'(bus.out_count), 32'd0);
        check({tag, ".overflow_err"}, 32'(bus.overflow_err), 32'd0);
    endtask

    task automatic check_hold(input string tag, input logic [15:0] imm, input logic [2:0] cnt,
                              input logic err);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, ".out_imm"}, 32'(bus.out_imm), 32'(imm));
        check({tag, ".out_count"}, 32'(bus.out_count), 32'(cnt));
        check({tag, ".overflow_err"}, 32'(bus.overflow_err), 32'(err));
    endtask

    task automatic send(input logic [3:0] nib, input logic last);
        bus.in_valid  = 1'b1;
        bus.in_nibble = nib;
        bus.in_last   = last;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
    endtask

    initial begin
        int          acc_cyc[$];
        logic [15:0] imms[$];

        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_nibble = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");

        // Single negative nibble.
        bus.out_ready = 1'b1;
        send(4'h9, 1'b1);
        check_hold("single9", 16'hFFF9, 3'd1, 1'b0);
        tick();
        check_idle("single9_after");

        // Two-nibble chains, positive then negative leading nibble.
        send(4'h7, 1'b0);
        check("accum.in_ready", 32'(bus.in_ready), 32'd1);
        check("accum.out_valid", 32'(bus.out_valid), 32'd0);
        send(4'hA, 1'b1);
        check_hold("chain7A", 16'h007A, 3'd2, 1'b0);
        tick();
        send(4'hF, 1'b0);
        send(4'h3, 1'b1);
        check_hold("chainF3", 16'hFFF3, 3'd2, 1'b0);
        tick();

        // Four nibbles without in_last: forced termination with error.
        send(4'hF, 1'b0);
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        check_hold("overflow", 16'hF123, 3'd4, 1'b1);
        tick();
        check_idle("overflow_after");

        // Four nibbles with in_last on the 4th: no error.
        send(4'h8, 1'b0);
        send(4'h0, 1'b0);
        send(4'h0, 1'b0);
        send(4'h1, 1'b1);
        check_hold("full_last", 16'h8001, 3'd4, 1'b0);
        tick();

        // Consumer stalls for 3 cycles; result must stay stable.
        bus.out_ready = 1'b0;
        send(4'h4, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_nibble = 4'hC;
        for (int i = 0; i < 3; i++) begin
            check_hold($sformatf("stall%0d", i), 16'h0004, 3'd1, 1'b0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check_hold("stall_release", 16'h0004, 3'd1, 1'b0);
        tick();
        check_idle("stall_after");

        // Reset mid-chain discards the partial chain.
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("midreset");
        send(4'h3, 1'b1);
        check_hold("after_reset", 16'h0003, 3'd1, 1'b0);
        tick();

        // Back-to-back single-nibble chains with valid and ready held high.
        bus.in_valid  = 1'b1;
        bus.in_nibble = 4'h8;
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (acc_cyc.size() == 1) bus.in_nibble = 4'h5;
            if (acc_cyc.size() == 2) bus.in_valid = 1'b0;
            if (bus.out_valid) imms.push_back(bus.out_imm);
            if (bus.in_valid && bus.in_ready) acc_cyc.push_back(c);
            tick();
        end
        bus.in_last = 1'b0;
        check("b2b.accepts", 32'(acc_cyc.size()), 32'd2);
        check("b2b.results", 32'(imms.size()), 32'd2);
        if (acc_cyc.size() == 2) check("b2b.spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
        if (imms.size() == 2) begin
            check("b2b.imm0", 32'(imms[0]), 32'h0000FFF8);
            check("b2b.imm1", 32'(imms[1]), 32'h00000005);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_sequencer.md
Name: imm_sequencer

Overview:
Sequences the 4-bit-to-16-bit sign extender so the CPU can build 16-bit immediates from prefix chains of 1 to 4 nibbles. The first nibble of a chain is sign-extended. Each following nibble is shifted in at the least-significant end. The block sits between the decode stage, which streams nibbles with valid/ready, and the ALU operand-B mux, which consumes the finished immediate with valid/ready.

Parameters:
DATA_W, 16, width of the finished immediate.
NIB_W, 4, width of one immediate nibble.
MAX_NIBS, DATA_W/NIB_W (4), maximum nibbles per chain.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  decode presents a nibble.
in_ready  output  1  sequencer can accept a nibble.
in_nibble  input  NIB_W  immediate nibble; the first nibble of a chain is most significant.
in_last  input  1  marks the final nibble of the chain.
out_valid  output  1  finished immediate available.
out_ready  input  1  consumer takes the immediate.
out_imm  output  DATA_W  finished signed immediate.
out_count  output  3  number of nibbles in the chain (1..4).
overflow_err  output  1  chain hit MAX_NIBS without in_last.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE, acc=0, count=0, err=0. Outputs after reset: in_ready=1, out_valid=0, out_imm=0, out_count=0, overflow_err=0.
- Reset mid-chain or while in HOLD: the partial chain is discarded. Nothing is emitted for it.
- State IDLE:
  - in_ready=1.
  - On accept (in_valid&&in_ready): acc<=sext(in_nibble) via sub-module; count<=1; err<=0.
  - Next state is HOLD if in_last, else ACCUM.
- State ACCUM:
  - in_ready=1.
  - On accept: acc<={acc[DATA_W-NIB_W-1:0], in_nibble}; count<=count+1.
  - If in_last, next state is HOLD.
  - Else if count+1==MAX_NIBS, next state is HOLD and err<=1 (forced termination).
  - Else stay in ACCUM.
  - No accept: hold all state.
- State HOLD:
  - in_ready=0; out_valid=1; out_imm=acc; out_count=count; overflow_err=err.
  - On out_ready: next state is IDLE.
  - While out_valid&&!out_ready, out_imm, out_count and overflow_err stay stable.
- Latency and throughput:
  - out_valid rises the cycle after the last nibble is accepted.
  - The next chain's first nibble is accepted no earlier than the cycle after the output handshake. There is no same-cycle bypass.
- out_imm, out_count and overflow_err are 0 whenever out_valid=0.
- Arithmetic: the result is the two's-complement value whose top nibble is the first nibble. Shifting drops the top NIB_W bits of acc; with MAX_NIBS=4, only sign-extension bits are dropped.
- in_last asserted together with the 4th nibble gives err=0.
- in_valid in HOLD is ignored. Decode must hold the nibble until in_ready.

Decomposition:
- Shared package cpu_pkg holds: DATA_W, NIB_W, MAX_NIBS constants; the state enum {IDLE, ACCUM, HOLD}.
- One sub-module: the existing signExtender, instantiated once on in_nibble, for the first-nibble path.
- The FSM, the shift accumulator and the counter stay in imm_sequencer.

Test Plan:
- Single nibble 0x9 with in_last, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFF9, out_count=1, overflow_err=0; the cycle after that, in_ready=1.
- Nibbles 0x7, 0xA (last) -> out_imm=0x007A, out_count=2. Then nibbles 0xF, 0x3 (last) -> out_imm=0xFFF3.
- Nibbles 0xF, 0x1, 0x2, 0x3 with in_last never asserted -> out_imm=0xF123, out_count=4, overflow_err=1; in_ready=0 the cycle after the 4th accept.
- Single nibble 0x4 (last), out_ready held low 3 cycles then high -> out_valid stays 1 with out_imm=0x0004 stable and in_ready=0 throughout; IDLE on the 4th cycle.
- Nibbles 0x1, 0x2 accepted, then rst for 1 cycle -> out_valid=0, in_ready=1, outputs 0. Then a new single nibble 0x3 (last) -> out_imm=0x0003, out_count=1.
- Back-to-back chains 0x8 (last) and 0x5 (last) with in_valid and out_ready held high -> 0xFFF8 then 0x0005, with accepts exactly 2 cycles apart.
